// File: rtl/breath_duty_ramp_if.sv
// Bundles the breathing-ramp control inputs and the duty/status outputs.
`default_nettype none
`timescale 1ns/1ps

interface breath_duty_ramp_if #(
  parameter int pWIDTH = 20
);
  logic              en;
  logic              period_tick;
  logic [pWIDTH-1:0] duty;
  logic              duty_valid;
  logic              pwm_en;
  logic [2:0]        phase;
  logic              cycle_done;

  modport master (
    output en, period_tick,
    input  duty, duty_valid, pwm_en, phase, cycle_done
  );

  modport slave (
    input  en, period_tick,
    output duty, duty_valid, pwm_en, phase, cycle_done
  );
endinterface

`default_nettype wire

// File: rtl/breath_duty_ramp.sv
// breath_duty_ramp: period-aligned duty ramp (rise, hold, fall, hold) for the breathing-LED PWM.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module breath_duty_ramp #(
  parameter int pWIDTH  = 20,
  parameter int pPERIOD = 1000000,
  parameter int pSTEP   = 20000,
  parameter int pHOLD   = 50
) (
  input  logic                   clk,
  input  logic                   rst_n,
  breath_duty_ramp_if.slave      bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  localparam int                HW        = (pHOLD > 1) ? $clog2(pHOLD) : 1;
  localparam logic [HW-1:0]     HOLD_LAST = HW'(pHOLD - 1);
  localparam logic [pWIDTH-1:0] PERIOD_N  = pWIDTH'(pPERIOD);
  localparam logic [pWIDTH-1:0] STEP_N    = pWIDTH'(pSTEP);

  state_t            state_q;
  logic [pWIDTH-1:0] duty_q;
  logic [HW-1:0]     hold_q;
  logic              dv_q;
  logic              pwm_en_q;
  logic              cd_q;

  // Limit tests are done one bit wider so PERIOD-STEP and the step compare never wrap.
  logic [pWIDTH:0]   rise_lim_d;
  logic              at_top_d;
  logic              at_bot_d;
  logic [pWIDTH-1:0] duty_up_d;
  logic [pWIDTH-1:0] duty_dn_d;

  assign rise_lim_d = {1'b0, PERIOD_N} - {1'b0, STEP_N};
  assign at_top_d   = {1'b0, duty_q} >= rise_lim_d;
  assign at_bot_d   = {1'b0, duty_q} <= {1'b0, STEP_N};
  assign duty_up_d  = duty_q + STEP_N;
  assign duty_dn_d  = duty_q - STEP_N;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      hold_q   <= '0;
      dv_q     <= 1'b0;
      pwm_en_q <= 1'b0;
      cd_q     <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      cd_q <= 1'b0;
      if (!bus.en) begin
        state_q  <= IDLE;
        duty_q   <= '0;
        hold_q   <= '0;
        pwm_en_q <= 1'b0;
      end else begin
        pwm_en_q <= 1'b1;
        case (state_q)
          IDLE: begin
            // The tick coinciding with enable is deliberately dropped.
            state_q <= RISE;
          end
          RISE: if (bus.period_tick) begin
            dv_q <= 1'b1;
            if (at_top_d) begin
              duty_q  <= PERIOD_N;
              hold_q  <= '0;
              state_q <= HOLD_HI;
            end else begin
              duty_q  <= duty_up_d;
            end
          end
          HOLD_HI: if (bus.period_tick) begin
            if (hold_q == HOLD_LAST) begin
              hold_q  <= '0;
              state_q <= FALL;
            end else begin
              hold_q  <= hold_q + 1'b1;
            end
          end
          FALL: if (bus.period_tick) begin
            dv_q <= 1'b1;
            if (at_bot_d) begin
              duty_q  <= '0;
              hold_q  <= '0;
              state_q <= HOLD_LO;
            end else begin
              duty_q  <= duty_dn_d;
            end
          end
          HOLD_LO: if (bus.period_tick) begin
            if (hold_q == HOLD_LAST) begin
              hold_q  <= '0;
              cd_q    <= 1'b1;
              state_q <= RISE;
            end else begin
              hold_q  <= hold_q + 1'b1;
            end
          end
          default: begin
            state_q  <= IDLE;
            duty_q   <= '0;
            hold_q   <= '0;
            pwm_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.duty       = duty_q;
  assign bus.duty_valid = dv_q;
  assign bus.pwm_en     = pwm_en_q;
  assign bus.phase      = state_q;
  assign bus.cycle_done = cd_q;

endmodule

`default_nettype wire

// File: tb/tb_breath_duty_ramp.sv
// Scoreboard bench: two ramps (step 30 and step 25) driven by the same en/tick stimulus.
`default_nettype none
`timescale 1ns/1ps

module tb_breath_duty_ramp;

  localparam int W    = 8;
  localparam int PER  = 100;
  localparam int HOLD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic tick  = 1'b0;

  breath_duty_ramp_if #(.pWIDTH(W)) ifa ();
  breath_duty_ramp_if #(.pWIDTH(W)) ifb ();

  assign ifa.en          = en;
  assign ifa.period_tick = tick;
  assign ifb.en          = en;
  assign ifb.period_tick = tick;

  breath_duty_ramp #(.pWIDTH(W), .pPERIOD(PER), .pSTEP(30), .pHOLD(HOLD)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  breath_duty_ramp #(.pWIDTH(W), .pPERIOD(PER), .pSTEP(25), .pHOLD(HOLD)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state, index 0 = step 30, index 1 = step 25.
  int m_ph[2];
  int m_duty[2];
  int m_hold[2];
  int m_dv[2];
  int m_cd[2];
  int q0[$];
  int q1[$];

  function automatic int step_of(input int k);
    return (k == 0) ? 30 : 25;
  endfunction

  function automatic void push_exp(input int k, input int v);
    if (k == 0) q0.push_back(v);
    else        q1.push_back(v);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_duty[k] = 0; m_hold[k] = 0; m_dv[k] = 0; m_cd[k] = 0;
    end
    q0.delete();
    q1.delete();
  endfunction

  function automatic void model_cycle(input int k, input bit e, input bit t);
    int s;
    s = step_of(k);
    m_dv[k] = 0;
    m_cd[k] = 0;
    if (!e) begin
      m_ph[k] = 0; m_duty[k] = 0; m_hold[k] = 0;
    end else if (m_ph[k] == 0) begin
      m_ph[k] = 1;
    end else if (t) begin
      case (m_ph[k])
        1: begin
          if (m_duty[k] >= PER - s) begin
            m_duty[k] = PER; m_ph[k] = 2; m_hold[k] = 0;
          end else m_duty[k] = m_duty[k] + s;
          m_dv[k] = 1;
          push_exp(k, m_duty[k]);
        end
        2: begin
          if (m_hold[k] == HOLD - 1) begin m_ph[k] = 3; m_hold[k] = 0; end
          else m_hold[k]++;
        end
        3: begin
          if (m_duty[k] <= s) begin
            m_duty[k] = 0; m_ph[k] = 4; m_hold[k] = 0;
          end else m_duty[k] = m_duty[k] - s;
          m_dv[k] = 1;
          push_exp(k, m_duty[k]);
        end
        default: begin
          if (m_hold[k] == HOLD - 1) begin m_ph[k] = 1; m_hold[k] = 0; m_cd[k] = 1; end
          else m_hold[k]++;
        end
      endcase
    end
  endfunction

  // One clock: drive at a falling edge, check registered outputs at the next falling edge.
  task automatic cyc(input bit e, input bit t);
    en   = e;
    tick = t;
    model_cycle(0, e, t);
    model_cycle(1, e, t);
    @(negedge clk);
    chk("A.phase",      int'(ifa.phase),      m_ph[0]);
    chk("A.duty",       int'(ifa.duty),       m_duty[0]);
    chk("A.pwm_en",     int'(ifa.pwm_en),     (m_ph[0] != 0) ? 1 : 0);
    chk("A.duty_valid", int'(ifa.duty_valid), m_dv[0]);
    chk("A.cycle_done", int'(ifa.cycle_done), m_cd[0]);
    chk("B.phase",      int'(ifb.phase),      m_ph[1]);
    chk("B.duty",       int'(ifb.duty),       m_duty[1]);
    chk("B.duty_valid", int'(ifb.duty_valid), m_dv[1]);
    chk("B.cycle_done", int'(ifb.cycle_done), m_cd[1]);
  endtask

  // Scoreboard consumers: every duty_valid pulse must match the oldest expected duty.
  always @(negedge clk) begin
    if (rst_n && ifa.duty_valid) begin
      if (q0.size() == 0) chk("A.sb_unexpected", 1, 0);
      else                chk("A.sb_duty", int'(ifa.duty), q0.pop_front());
    end
    if (rst_n && ifb.duty_valid) begin
      if (q1.size() == 0) chk("B.sb_unexpected", 1, 0);
      else                chk("B.sb_duty", int'(ifb.duty), q1.pop_front());
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, ".duty"},       int'(ifa.duty),       0);
    chk({tag, ".pwm_en"},     int'(ifa.pwm_en),     0);
    chk({tag, ".phase"},      int'(ifa.phase),      0);
    chk({tag, ".duty_valid"}, int'(ifa.duty_valid), 0);
    chk({tag, ".cycle_done"}, int'(ifa.cycle_done), 0);
    chk({tag, ".B.duty"},     int'(ifb.duty),       0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_state("rst_init");
    rst_n = 1'b1;

    // Full breath with a tick every 8 clocks, then one more rising step.
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 13; i++) begin
      cyc(1'b1, 1'b1);
      repeat (7) cyc(1'b1, 1'b0);
    end
    chk("breath_restart_A", int'(ifa.duty), 30);
    chk("breath_restart_B", int'(ifb.duty), 25);

    // Asynchronous reset mid-run, sampled between clock edges.
    #2 rst_n = 1'b0;
    #1 chk_reset_state("rst_async");
    model_reset();
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Enable coincident with a tick: tick ignored, first step on the next tick.
    cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("rise_60", int'(ifa.duty), 60);

    // Disable with a tick in the same cycle, then restart from zero.
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b1);

    // Back-to-back ticks, then a long idle gap.
    repeat (20) cyc(1'b1, 1'b1);
    repeat (1000) cyc(1'b1, 1'b0);

    cyc(1'b0, 1'b0);
    chk("A.sb_left", q0.size(), 0);
    chk("B.sb_left", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
